// File: rtl/mm_stream_param_pkg.sv
// Shared definitions for the streaming matrix multiplier: FSM state encoding and width helpers.
package mm_stream_param_pkg;

  typedef enum logic [2:0] {
    READ_A,
    READ_B,
    CHECK,
    MAC,
    EMIT,
    ERR,
    DONE
  } state_t;

  function automatic int idx_w(input int max_dim);
    return (max_dim < 2) ? 1 : $clog2(max_dim);
  endfunction

  // Narrowest out_data that holds a full dot product of MAX_DIM terms without wrap.
  function automatic int min_out_w(input int data_w, input int max_dim);
    return 2 * data_w + idx_w(max_dim) + 1;
  endfunction

endpackage

// File: rtl/mm_stream_param_mac.sv
// Extend/multiply/accumulate datapath: acc <= (clear ? 0 : acc) + ext(a) * ext(b) when enabled.
module mm_stream_param_mac
  import mm_stream_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 20,
  parameter int SIGNED = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic [DATA_W-1:0]        i_a,
  input  logic [DATA_W-1:0]        i_b,
  output logic signed [OUT_W-1:0]  o_acc
);

  logic                    w_a_sx;
  logic                    w_b_sx;
  logic signed [OUT_W-1:0] w_a_ext;
  logic signed [OUT_W-1:0] w_b_ext;
  logic signed [OUT_W-1:0] w_prod;
  logic signed [OUT_W-1:0] r_acc;

  assign w_a_sx  = (SIGNED != 0) ? i_a[DATA_W-1] : 1'b0;
  assign w_b_sx  = (SIGNED != 0) ? i_b[DATA_W-1] : 1'b0;
  assign w_a_ext = {{(OUT_W-DATA_W){w_a_sx}}, i_a};
  assign w_b_ext = {{(OUT_W-DATA_W){w_b_sx}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= (i_clear ? '0 : r_acc) + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mm_stream_param.sv
// Streaming C = A x B with runtime shapes up to MAX_DIM; first result 2+cols(A) cycles after busy rises.
// Input is held off with busy while computing; beats presented during busy are dropped.
module mm_stream_param
  import mm_stream_param_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 4,
  parameter int OUT_W   = 20,
  parameter int SIGNED  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_col_end,
  input  logic              i_row_end,
  output logic              o_busy,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_is_legal,
  output logic              o_change_row
);

  localparam int IDX_W = idx_w(MAX_DIM);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DIM);

  if (OUT_W < min_out_w(DATA_W, MAX_DIM)) begin : g_out_w_check
    $error("OUT_W too narrow for DATA_W and MAX_DIM");
  end

  state_t                  r_state;
  logic [DATA_W-1:0]       r_a [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0]       r_b [MAX_DIM][MAX_DIM];
  logic [CNT_W-1:0]        r_r, r_c;
  logic [CNT_W-1:0]        r_rows_a, r_cols_a, r_rows_b, r_cols_b;
  logic [IDX_W-1:0]        r_i, r_j, r_k;
  logic                    r_err;
  logic                    r_busy, r_valid, r_is_legal, r_change_row;
  logic [OUT_W-1:0]        r_out_data;

  logic                    w_beat, w_last_col, w_in_range, w_reading;
  logic [CNT_W-1:0]        w_c_next, w_r_next, w_cols_cur;
  logic                    w_k_last, w_j_last, w_i_last;
  logic signed [OUT_W-1:0] w_acc;

  assign w_reading  = (r_state == READ_A) || (r_state == READ_B);
  assign w_beat     = i_in_valid & ~r_busy & w_reading;
  assign w_last_col = i_col_end | i_row_end;
  assign w_in_range = (r_r < MAX_C) && (r_c < MAX_C);
  // Counters saturate at MAX_DIM; any beat landing there has already raised err.
  assign w_c_next   = (r_c == MAX_C) ? r_c : r_c + 1'b1;
  assign w_r_next   = (r_r == MAX_C) ? r_r : r_r + 1'b1;
  assign w_cols_cur = (r_state == READ_A) ? r_cols_a : r_cols_b;
  assign w_k_last   = ({1'b0, r_k} == r_cols_a - 1'b1);
  assign w_j_last   = ({1'b0, r_j} == r_cols_b - 1'b1);
  assign w_i_last   = ({1'b0, r_i} == r_rows_a - 1'b1);

  always_ff @(posedge i_clk) begin
    if (w_beat && w_in_range) begin
      if (r_state == READ_A) begin
        r_a[r_r[IDX_W-1:0]][r_c[IDX_W-1:0]] <= i_in_data;
      end else begin
        r_b[r_r[IDX_W-1:0]][r_c[IDX_W-1:0]] <= i_in_data;
      end
    end
  end

  mm_stream_param_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (r_k == '0),
    .i_en    (r_state == MAC),
    .i_a     (r_a[r_i][r_k]),
    .i_b     (r_b[r_k][r_j]),
    .o_acc   (w_acc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= READ_A;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_out_data   <= '0;
      r_is_legal   <= 1'b1;
      r_change_row <= 1'b0;
      r_r          <= '0;
      r_c          <= '0;
      r_rows_a     <= '0;
      r_cols_a     <= '0;
      r_rows_b     <= '0;
      r_cols_b     <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_err        <= 1'b0;
    end else begin
      r_valid      <= 1'b0;
      r_is_legal   <= 1'b1;
      r_change_row <= 1'b0;
      case (r_state)
        READ_A, READ_B: begin
          if (w_beat) begin
            if (!w_in_range) r_err <= 1'b1;
            if (w_last_col) begin
              if (r_r == '0) begin
                if (r_state == READ_A) r_cols_a <= w_c_next;
                else                   r_cols_b <= w_c_next;
              end else if (w_c_next != w_cols_cur) begin
                r_err <= 1'b1;
              end
              r_c <= '0;
              r_r <= w_r_next;
              if (i_row_end) begin
                r_r <= '0;
                if (r_state == READ_A) begin
                  r_rows_a <= w_r_next;
                  r_state  <= READ_B;
                end else begin
                  r_rows_b <= w_r_next;
                  r_busy   <= 1'b1;
                  r_state  <= CHECK;
                end
              end
            end else begin
              r_c <= w_c_next;
            end
          end
        end
        CHECK: begin
          r_i <= '0;
          r_j <= '0;
          r_k <= '0;
          r_state <= (r_err || (r_cols_a != r_rows_b)) ? ERR : MAC;
        end
        MAC: begin
          if (w_k_last) r_state <= EMIT;
          else          r_k <= r_k + 1'b1;
        end
        EMIT: begin
          r_valid      <= 1'b1;
          r_out_data   <= w_acc;
          r_change_row <= w_j_last;
          r_k          <= '0;
          r_state      <= MAC;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
            if (w_i_last) r_state <= DONE;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        ERR: begin
          r_valid    <= 1'b1;
          r_is_legal <= 1'b0;
          r_out_data <= '0;
          r_state    <= DONE;
        end
        DONE: begin
          r_busy   <= 1'b0;
          r_rows_a <= '0;
          r_cols_a <= '0;
          r_rows_b <= '0;
          r_cols_b <= '0;
          r_r      <= '0;
          r_c      <= '0;
          r_err    <= 1'b0;
          r_state  <= READ_A;
        end
        default: r_state <= READ_A;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_valid      = r_valid;
  assign o_out_data   = r_out_data;
  assign o_is_legal   = r_is_legal;
  assign o_change_row = r_change_row;

endmodule

// File: tb/tb_mm_stream_param.sv
// Directed bench for mm_stream_param: table of matrix pairs plus reset-during-compute sequence.
module tb_mm_stream_param;

  localparam int DW = 8;
  localparam int MD = 4;
  localparam int OW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, col_end, row_end;
  logic [DW-1:0] in_data;
  logic          busy, valid, is_legal, change_row;
  logic [OW-1:0] out_data;

  always #5 clk = ~clk;

  mm_stream_param #(.DATA_W(DW), .MAX_DIM(MD), .OUT_W(OW), .SIGNED(1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .i_col_end    (col_end),
    .i_row_end    (row_end),
    .o_busy       (busy),
    .o_valid      (valid),
    .o_out_data   (out_data),
    .o_is_legal   (is_legal),
    .o_change_row (change_row)
  );

  typedef struct packed {
    logic [2:0]        ra, ca, rb, cb;
    logic [24:0][7:0]  a, b;
    logic              gaps, re_only;
    logic              legal;
    logic [4:0]        n;
    logic [15:0][19:0] ex;
    logic [15:0]       cr;
  } vec_t;

  localparam int NV = 9;
  vec_t tv [NV];

  int n_chk = 0;
  int n_bad = 0;

  // Output monitor: every valid pulse is logged with the cycle it was seen in.
  int          cyc = 0;
  int          rise_cyc = 0, fall_cyc = 0, fall_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [19:0] res_dat[$];
  bit          res_leg[$], res_cr[$];
  int          res_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      res_dat.push_back(out_data);
      res_leg.push_back(is_legal);
      res_cr.push_back(change_row);
      res_cyc.push_back(cyc);
    end
    if (busy === 1'b1 && prev_busy == 1'b0) rise_cyc = cyc;
    if (busy === 1'b0 && prev_busy == 1'b1) begin
      fall_cyc = cyc;
      fall_cnt++;
    end
    prev_busy = busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_data  = 8'hA5;
    col_end  = 1'b1;
    row_end  = 1'b1;
  endtask

  task automatic clear_log();
    res_dat.delete();
    res_leg.delete();
    res_cr.delete();
    res_cyc.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_chk++;
      n_bad++;
      $display("FAIL idle_timeout: busy=%b, want 0", busy);
    end
  endtask

  task automatic send_mat(input int r, input int c, input logic [24:0][7:0] m,
                          input bit gaps, input bit re_only);
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < c; cc++) begin
        if (gaps && (((rr * c + cc) % 2) == 1)) begin
          @(posedge clk); #1;
          drive_idle();
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = m[rr * c + cc];
        row_end  = (rr == r - 1) && (cc == c - 1);
        col_end  = (cc == c - 1) && !(re_only && row_end);
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic run_case(input int i);
    vec_t v;
    int   ca, ne, f0, n;
    v  = tv[i];
    ca = int'(v.ca);
    ne = int'(v.n);
    wait_idle();
    clear_log();
    f0 = fall_cnt;
    send_mat(v.ra, v.ca, v.a, v.gaps, v.re_only);
    send_mat(v.rb, v.cb, v.b, v.gaps, v.re_only);
    if (v.gaps) begin
      // Beats offered while busy must be ignored.
      for (int g = 0; g < 4; g++) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        col_end  = 1'b1;
        row_end  = 1'b1;
      end
      drive_idle();
    end
    n = 0;
    while (fall_cnt == f0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (fall_cnt == f0) begin
      n_chk++;
      n_bad++;
      $display("FAIL c%0d_done_timeout: busy never fell, want fall", i);
    end
    chk($sformatf("c%0d_count", i), res_dat.size(), ne);
    for (int k = 0; k < res_dat.size() && k < ne; k++) begin
      chk($sformatf("c%0d_data%0d", i, k), {12'd0, res_dat[k]}, {12'd0, v.ex[k]});
      chk($sformatf("c%0d_legal%0d", i, k), res_leg[k], v.legal);
      chk($sformatf("c%0d_chrow%0d", i, k), res_cr[k], v.cr[k]);
      if (k > 0) chk($sformatf("c%0d_spacing%0d", i, k), res_cyc[k] - res_cyc[k-1], ca + 1);
    end
    if (res_dat.size() > 0) begin
      chk($sformatf("c%0d_latency", i), res_cyc[0] - rise_cyc, v.legal ? ca + 2 : 2);
      chk($sformatf("c%0d_busy_fall", i), fall_cyc - res_cyc[res_dat.size()-1], 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++) tv[i] = '0;

    // 0: 2x2 * 2x2
    tv[0].ra = 2; tv[0].ca = 2; tv[0].rb = 2; tv[0].cb = 2;
    tv[0].a[0] = 1; tv[0].a[1] = 2; tv[0].a[2] = 3; tv[0].a[3] = 4;
    tv[0].b[0] = 5; tv[0].b[1] = 6; tv[0].b[2] = 7; tv[0].b[3] = 8;
    tv[0].legal = 1; tv[0].n = 4;
    tv[0].ex[0] = 19; tv[0].ex[1] = 22; tv[0].ex[2] = 43; tv[0].ex[3] = 50;
    tv[0].cr = 16'b1010;
    // 1: cols(A)=3 vs rows(B)=2
    tv[1].ra = 2; tv[1].ca = 3; tv[1].rb = 2; tv[1].cb = 2;
    for (int k = 0; k < 6; k++) tv[1].a[k] = 8'(k + 1);
    tv[1].b[0] = 1; tv[1].b[3] = 1;
    tv[1].legal = 0; tv[1].n = 1; tv[1].ex[0] = 0;
    // 2: 1x1 most-negative squared
    tv[2].ra = 1; tv[2].ca = 1; tv[2].rb = 1; tv[2].cb = 1;
    tv[2].a[0] = 8'h80; tv[2].b[0] = 8'h80;
    tv[2].legal = 1; tv[2].n = 1; tv[2].ex[0] = 16384; tv[2].cr = 16'b1;
    // 3: [-1 2] * [3;4]
    tv[3].ra = 1; tv[3].ca = 2; tv[3].rb = 2; tv[3].cb = 1;
    tv[3].a[0] = 8'hFF; tv[3].a[1] = 2; tv[3].b[0] = 3; tv[3].b[1] = 4;
    tv[3].legal = 1; tv[3].n = 1; tv[3].ex[0] = 5; tv[3].cr = 16'b1;
    // 4: 4x4 full of 127
    tv[4].ra = 4; tv[4].ca = 4; tv[4].rb = 4; tv[4].cb = 4;
    for (int k = 0; k < 16; k++) begin
      tv[4].a[k] = 127; tv[4].b[k] = 127; tv[4].ex[k] = 64516;
    end
    tv[4].legal = 1; tv[4].n = 16; tv[4].cr = 16'h8888;
    // 5: row of 5 elements overflows MAX_DIM
    tv[5].ra = 1; tv[5].ca = 5; tv[5].rb = 5; tv[5].cb = 1;
    for (int k = 0; k < 5; k++) begin
      tv[5].a[k] = 1; tv[5].b[k] = 1;
    end
    tv[5].legal = 0; tv[5].n = 1; tv[5].ex[0] = 0;
    // 6: mixed-sign 2x2 with input gaps
    tv[6].ra = 2; tv[6].ca = 2; tv[6].rb = 2; tv[6].cb = 2; tv[6].gaps = 1;
    tv[6].a[0] = 2; tv[6].a[1] = 8'hFD; tv[6].a[2] = 1; tv[6].a[3] = 3;
    tv[6].b[0] = 4; tv[6].b[1] = 1; tv[6].b[2] = 8'hFE; tv[6].b[3] = 5;
    tv[6].legal = 1; tv[6].n = 4;
    tv[6].ex[0] = 14; tv[6].ex[1] = -20'sd13; tv[6].ex[2] = -20'sd2; tv[6].ex[3] = 16;
    tv[6].cr = 16'b1010;
    // 7: 2x3 * 3x1, gaps, last beat with row_end only
    tv[7].ra = 2; tv[7].ca = 3; tv[7].rb = 3; tv[7].cb = 1; tv[7].gaps = 1; tv[7].re_only = 1;
    for (int k = 0; k < 6; k++) tv[7].a[k] = 8'(k + 1);
    tv[7].b[0] = 1; tv[7].b[1] = 0; tv[7].b[2] = 8'hFF;
    tv[7].legal = 1; tv[7].n = 2; tv[7].ex[0] = -20'sd2; tv[7].ex[1] = -20'sd2;
    tv[7].cr = 16'b11;
    // 8: back to a plain pair after everything else
    tv[8] = tv[0];

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", out_data, 20'd0);
    chk("rst_legal", is_legal, 1'b1);
    chk("rst_chrow", change_row, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_case(i);

    // Reset while the second element of C is being accumulated.
    begin
      int n = 0;
      wait_idle();
      clear_log();
      send_mat(2, 2, tv[0].a, 1'b0, 1'b0);
      send_mat(2, 2, tv[0].b, 1'b0, 1'b0);
      while (res_dat.size() < 1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("mid_first_seen", res_dat.size(), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", valid, 1'b0);
      chk("mid_rst_data", out_data, 20'd0);
      chk("mid_rst_legal", is_legal, 1'b1);
      chk("mid_rst_chrow", change_row, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_no_more_results", res_dat.size(), 1);
    end
    run_case(0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
